// File: rtl/vz_image_loader_pkg.sv
// Shared constants, FSM state encoding and header helpers for the VZ snapshot loader.
package vz_pkg;

  localparam logic [31:0] VZ_MAGIC_VZF0 = 32'h565A_4630;
  localparam logic [31:0] VZ_MAGIC_ALT  = 32'h2020_0000;
  localparam logic [7:0]  VZ_TYPE_BASIC = 8'hF0;
  localparam logic [7:0]  VZ_TYPE_BIN   = 8'hF1;
  localparam logic [15:0] VZ_HDR_LEN    = 16'd24;

  localparam logic [15:0] VZ_OFS_MAGIC_END = 16'd3;
  localparam logic [15:0] VZ_OFS_TYPE      = 16'd21;
  localparam logic [15:0] VZ_OFS_START_LO  = 16'd22;
  localparam logic [15:0] VZ_OFS_START_HI  = 16'd23;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_FLUSH,
    ST_POST_LO,
    ST_POST_HI,
    ST_DONE,
    ST_ERROR
  } vz_state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } vz_entry_t;

  function automatic logic vz_magic_ok(input logic [31:0] magic);
    return (magic == VZ_MAGIC_VZF0) || (magic == VZ_MAGIC_ALT);
  endfunction

  function automatic logic vz_type_ok(input logic [7:0] typ);
    return (typ == VZ_TYPE_BASIC) || (typ == VZ_TYPE_BIN);
  endfunction

endpackage

// File: rtl/vz_image_loader_if.sv
// Download channel (from hps_io) plus the req/ack memory write port; the loader is the master.
interface vz_image_loader_if;

  logic        dn_download;
  logic        dn_wr;
  logic [7:0]  dn_index;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;

  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;

  modport master (
    input  dn_download, dn_wr, dn_index, dn_addr, dn_data, mem_ack,
    output mem_req, mem_addr, mem_data
  );

  modport slave (
    output dn_download, dn_wr, dn_index, dn_addr, dn_data, mem_ack,
    input  mem_req, mem_addr, mem_data
  );

endinterface

// File: rtl/vz_fifo.sv
// Small synchronous FIFO; push and pop may coincide at any occupancy, including full.
module vz_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk_sys,
  input  logic             RESET_N,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot the push is about to fill.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_dout  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vz_image_loader.sv
// Parses a .VZ header from the ioctl download stream, writes the payload to memory,
// then patches the BASIC end pointer or the USR vector.
module vz_image_loader
  import vz_pkg::*;
#(
  parameter logic [7:0]  VZ_INDEX   = 8'd1,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] SYSVAR_END = 16'h78F9,
  parameter logic [15:0] SYSVAR_USR = 16'h788E
) (
  input  logic                    clk_sys,
  input  logic                    RESET_N,
  vz_image_loader_if.master       bus,
  output logic                    cpu_hold,
  output logic [7:0]              load_type,
  output logic [15:0]             start_addr,
  output logic                    done,
  output logic                    err
);

  vz_state_e   r_state;
  vz_state_e   w_state_next;
  logic        r_dl_prev;
  logic [23:0] r_magic;
  logic [7:0]  r_load_type;
  logic [15:0] r_start_addr;
  logic [15:0] r_end_addr;
  logic        r_mem_req;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_mem_data;

  logic        w_start, w_fall, w_strobe, w_hdr_strobe, w_data_strobe;
  logic        w_pop, w_fifo_pop, w_push, w_overflow, w_full, w_empty;
  logic        w_post, w_issue;
  logic [15:0] w_push_addr, w_post_addr, w_post_value;
  logic [7:0]  w_post_data;
  vz_entry_t   w_head, w_push_entry;

  assign w_start       = bus.dn_download & ~r_dl_prev & (bus.dn_index == VZ_INDEX);
  assign w_fall        = ~bus.dn_download & r_dl_prev;
  assign w_strobe      = bus.dn_wr & (bus.dn_index == VZ_INDEX) & ~w_start;
  assign w_hdr_strobe  = w_strobe & (r_state == ST_HEADER) & ~w_fall;
  assign w_data_strobe = w_strobe & (r_state == ST_DATA) & ~w_fall & (bus.dn_addr >= VZ_HDR_LEN);

  assign w_post      = (r_state == ST_POST_LO) || (r_state == ST_POST_HI);
  assign w_pop       = r_mem_req & bus.mem_ack;
  assign w_fifo_pop  = w_pop & ~w_post;
  assign w_overflow  = w_data_strobe & w_full & ~w_fifo_pop;
  assign w_push      = w_data_strobe & ~w_overflow;
  assign w_push_addr = r_start_addr + (bus.dn_addr - VZ_HDR_LEN);
  assign w_push_entry = {w_push_addr, bus.dn_data};

  assign w_issue = ~r_mem_req &
                   ((((r_state == ST_DATA) || (r_state == ST_FLUSH)) & ~w_empty) | w_post);

  vz_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (24)
  ) u_fifo (
    .clk_sys (clk_sys),
    .RESET_N (RESET_N),
    .i_flush (w_start),
    .i_push  (w_push),
    .i_din   (w_push_entry),
    .i_pop   (w_fifo_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= ST_IDLE;
      r_dl_prev <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_dl_prev <= bus.dn_download;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_start) begin
      w_state_next = ST_HEADER;
    end else begin
      case (r_state)
        ST_HEADER: begin
          if (w_fall) begin
            w_state_next = ST_ERROR;
          end else if (w_hdr_strobe) begin
            if (bus.dn_addr == VZ_OFS_MAGIC_END && !vz_magic_ok({r_magic, bus.dn_data}))
              w_state_next = ST_ERROR;
            else if (bus.dn_addr == VZ_OFS_TYPE && !vz_type_ok(bus.dn_data))
              w_state_next = ST_ERROR;
            else if (bus.dn_addr == VZ_OFS_START_HI)
              w_state_next = ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_fall)          w_state_next = ST_FLUSH;
          else if (w_overflow) w_state_next = ST_ERROR;
        end
        ST_FLUSH:   if (w_empty) w_state_next = ST_POST_LO;
        ST_POST_LO: if (w_pop)   w_state_next = ST_POST_HI;
        ST_POST_HI: if (w_pop)   w_state_next = ST_DONE;
        ST_DONE:    w_state_next = ST_IDLE;
        default:    w_state_next = r_state;
      endcase
    end
  end

  always_comb begin
    cpu_hold = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (r_state)
      ST_HEADER, ST_DATA, ST_FLUSH, ST_POST_LO, ST_POST_HI: cpu_hold = 1'b1;
      ST_DONE:  done = 1'b1;
      ST_ERROR: err  = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      r_magic      <= '0;
      r_load_type  <= '0;
      r_start_addr <= '0;
      r_end_addr   <= '0;
    end else begin
      if (w_hdr_strobe) begin
        case (bus.dn_addr)
          16'd0:           r_magic[23:16]     <= bus.dn_data;
          16'd1:           r_magic[15:8]      <= bus.dn_data;
          16'd2:           r_magic[7:0]       <= bus.dn_data;
          VZ_OFS_TYPE:     r_load_type        <= bus.dn_data;
          VZ_OFS_START_LO: r_start_addr[7:0]  <= bus.dn_data;
          VZ_OFS_START_HI: begin
            r_start_addr[15:8] <= bus.dn_data;
            r_end_addr         <= {bus.dn_data, r_start_addr[7:0]};
          end
          default: ;
        endcase
      end
      if (w_push) r_end_addr <= w_push_addr + 16'd1;
    end
  end

  // BASIC images patch the end-of-program pointer, binaries the USR vector.
  always_comb begin
    w_post_addr  = (r_load_type == VZ_TYPE_BASIC) ? SYSVAR_END : SYSVAR_USR;
    w_post_value = (r_load_type == VZ_TYPE_BASIC) ? r_end_addr : r_start_addr;
    w_post_data  = w_post_value[7:0];
    if (r_state == ST_POST_HI) begin
      w_post_addr = w_post_addr + 16'd1;
      w_post_data = w_post_value[15:8];
    end
  end

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else if (w_start || w_state_next == ST_ERROR || w_pop) begin
      r_mem_req <= 1'b0;
    end else if (w_issue) begin
      r_mem_req  <= 1'b1;
      r_mem_addr <= w_post ? w_post_addr : w_head.addr;
      r_mem_data <= w_post ? w_post_data : w_head.data;
    end
  end

  assign bus.mem_req  = r_mem_req;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_data = r_mem_data;
  assign load_type    = r_load_type;
  assign start_addr   = r_start_addr;

endmodule

// File: tb/tb_vz_image_loader.sv
// Directed and randomized VZ downloads against a write-list reference model and a memory responder.
module tb_vz_image_loader;
  import vz_pkg::*;

  logic        clk_sys = 1'b0;
  logic        RESET_N = 1'b0;
  logic        cpu_hold, done, err;
  logic [7:0]  load_type;
  logic [15:0] start_addr;

  vz_image_loader_if bus ();

  vz_image_loader #(
    .VZ_INDEX   (8'd1),
    .FIFO_DEPTH (4),
    .SYSVAR_END (16'h78F9),
    .SYSVAR_USR (16'h788E)
  ) dut (
    .clk_sys    (clk_sys),
    .RESET_N    (RESET_N),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .load_type  (load_type),
    .start_addr (start_addr),
    .done       (done),
    .err        (err)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk_sys) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks ack_lat cycles after seeing a request, logs accepted writes.
  bit          ack_en = 1'b1;
  int          ack_lat = 1;
  int          lat_cnt = 0;
  bit          prev_req = 1'b0;
  logic [15:0] prev_addr;
  logic [7:0]  prev_data;
  int          req_cycles = 0;
  int          ack_cyc = 0;
  logic [15:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];

  always @(negedge clk_sys) begin
    if (!RESET_N) begin
      bus.mem_ack = 1'b0;
      lat_cnt     = 0;
      prev_req    = 1'b0;
    end else if (bus.mem_ack) begin
      chk("req_drop_after_ack", bus.mem_req, 1'b0);
      bus.mem_ack = 1'b0;
      prev_req    = 1'b0;
      lat_cnt     = 0;
    end else if (bus.mem_req === 1'b1) begin
      req_cycles++;
      if (prev_req) begin
        chk("mem_addr_stable", bus.mem_addr, prev_addr);
        chk("mem_data_stable", bus.mem_data, prev_data);
      end
      prev_req  = 1'b1;
      prev_addr = bus.mem_addr;
      prev_data = bus.mem_data;
      if (ack_en && lat_cnt >= ack_lat) begin
        bus.mem_ack = 1'b1;
        wr_addr_q.push_back(bus.mem_addr);
        wr_data_q.push_back(bus.mem_data);
        ack_cyc = cyc;
      end else begin
        lat_cnt++;
      end
    end else begin
      prev_req = 1'b0;
      lat_cnt  = 0;
    end
  end

  int done_cnt = 0;
  int done_cyc = 0;
  always @(negedge clk_sys) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  logic [7:0]  file_q [$];
  logic [7:0]  pay_q  [$];
  logic [15:0] exp_a  [$];
  logic [7:0]  exp_d  [$];

  task automatic put_byte(input logic [15:0] a, input logic [7:0] d, input int gap);
    bus.dn_wr   = 1'b1;
    bus.dn_addr = a;
    bus.dn_data = d;
    @(negedge clk_sys);
    bus.dn_wr = 1'b0;
    repeat (gap - 1) @(negedge clk_sys);
  endtask

  task automatic start_dl();
    bus.dn_index    = 8'd1;
    bus.dn_download = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic end_dl();
    bus.dn_download = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic build_file(input logic [31:0] magic, input logic [7:0] typ, input logic [15:0] st);
    file_q.delete();
    for (int b = 3; b >= 0; b--) file_q.push_back(magic[b*8 +: 8]);
    for (int b = 0; b < 17; b++) file_q.push_back(8'($urandom));
    file_q.push_back(typ);
    file_q.push_back(st[7:0]);
    file_q.push_back(st[15:8]);
    foreach (pay_q[i]) file_q.push_back(pay_q[i]);
  endtask

  // Expected write list: payload at consecutive (wrapping) addresses, then the two patch bytes.
  task automatic build_expected(input logic [7:0] typ, input logic [15:0] st);
    logic [15:0] endv;
    exp_a.delete();
    exp_d.delete();
    foreach (pay_q[i]) begin
      exp_a.push_back(st + 16'(i));
      exp_d.push_back(pay_q[i]);
    end
    endv = st + 16'(pay_q.size());
    if (typ == 8'hF0) begin
      exp_a.push_back(16'h78F9); exp_d.push_back(endv[7:0]);
      exp_a.push_back(16'h78FA); exp_d.push_back(endv[15:8]);
    end else begin
      exp_a.push_back(16'h788E); exp_d.push_back(st[7:0]);
      exp_a.push_back(16'h788F); exp_d.push_back(st[15:8]);
    end
  endtask

  task automatic compare_writes();
    int n;
    chk("write_count", wr_addr_q.size(), exp_a.size());
    n = (wr_addr_q.size() < exp_a.size()) ? wr_addr_q.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("write%0d_addr", i), wr_addr_q[i], exp_a[i]);
      chk($sformatf("write%0d_data", i), wr_data_q[i], exp_d[i]);
    end
  endtask

  task automatic run_full(input logic [31:0] magic, input logic [7:0] typ, input logic [15:0] st,
                          input int lat, input bit lat_chk);
    int base;
    int gap;
    int k;
    build_file(magic, typ, st);
    build_expected(typ, st);
    wr_addr_q.delete();
    wr_data_q.delete();
    ack_lat = lat;
    ack_en  = 1'b1;
    base    = done_cnt;
    start_dl();
    chk("hold_after_start", cpu_hold, 1'b1);
    chk("err_clear_at_start", err, 1'b0);
    for (int i = 0; i < 24; i++) put_byte(16'(i), file_q[i], 1);
    chk("load_type", load_type, typ);
    chk("start_addr", start_addr, st);
    for (int i = 0; i < pay_q.size(); i++) begin
      if (!(lat_chk && i == 0) && $urandom_range(0, 3) == 0) begin
        bus.dn_index = 8'd2;
        put_byte(16'(24 + i), 8'hEE, 1);
        bus.dn_index = 8'd1;
      end
      if (lat_chk && i == 0) begin
        put_byte(16'd24, file_q[24], 1);
        chk("req_latency_1", bus.mem_req, 1'b0);
        @(negedge clk_sys);
        chk("req_latency_2", bus.mem_req, 1'b1);
        repeat (lat + 2) @(negedge clk_sys);
      end else begin
        gap = lat + 2 + int'($urandom_range(0, 2));
        put_byte(16'(24 + i), file_q[24 + i], gap);
      end
    end
    end_dl();
    k = 0;
    while (done_cnt == base && err !== 1'b1 && k < 600) begin
      @(negedge clk_sys);
      k++;
    end
    chk("done_in_time", (k < 600), 1'b1);
    @(negedge clk_sys);
    chk("done_pulses", done_cnt - base, 1);
    chk("done_after_last_ack", done_cyc, ack_cyc + 1);
    chk("done_one_cycle", done, 1'b0);
    chk("err_after_done", err, 1'b0);
    chk("hold_after_done", cpu_hold, 1'b0);
    compare_writes();
  endtask

  task automatic fill_payload(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_base;
    logic [31:0] magic;
    logic [7:0]  typ;

    bus.dn_download = 1'b0;
    bus.dn_wr       = 1'b0;
    bus.dn_index    = 8'd0;
    bus.dn_addr     = 16'd0;
    bus.dn_data     = 8'd0;
    bus.mem_ack     = 1'b0;
    RESET_N         = 1'b0;
    repeat (3) @(negedge clk_sys);

    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_cpu_hold", cpu_hold, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0);
    chk("rst_mem_data", bus.mem_data, 8'h0);
    chk("rst_load_type", load_type, 8'h0);
    chk("rst_start_addr", start_addr, 16'h0);
    RESET_N = 1'b1;
    @(negedge clk_sys);

    // Strobe while idle must be ignored.
    bus.dn_index = 8'd1;
    put_byte(16'd0, 8'h56, 3);
    chk("idle_strobe_no_hold", cpu_hold, 1'b0);

    // BASIC image, three bytes.
    pay_q.delete();
    pay_q.push_back(8'h11); pay_q.push_back(8'h22); pay_q.push_back(8'h33);
    run_full(VZ_MAGIC_VZF0, VZ_TYPE_BASIC, 16'h7AE9, 1, 1'b1);

    // Binary image wrapping past FFFF, alternate magic.
    pay_q.delete();
    pay_q.push_back(8'hAA); pay_q.push_back(8'hBB);
    run_full(VZ_MAGIC_ALT, VZ_TYPE_BIN, 16'hFFFF, 0, 1'b1);

    // Bad magic.
    fill_payload(2);
    build_file(32'h5858_5858, VZ_TYPE_BASIC, 16'h3000);
    wr_addr_q.delete(); wr_data_q.delete();
    req_base = req_cycles;
    start_dl();
    for (int i = 0; i < 3; i++) put_byte(16'(i), file_q[i], 1);
    chk("magic_hold_before", cpu_hold, 1'b1);
    chk("magic_err_before", err, 1'b0);
    put_byte(16'd3, file_q[3], 1);
    chk("magic_err", err, 1'b1);
    chk("magic_hold_drop", cpu_hold, 1'b0);
    for (int i = 4; i < file_q.size(); i++) put_byte(16'(i), file_q[i], 1);
    end_dl();
    repeat (5) @(negedge clk_sys);
    chk("magic_no_req", req_cycles - req_base, 0);
    chk("magic_err_sticky", err, 1'b1);

    // FIFO overflow with the memory stalled.
    ack_en = 1'b0;
    fill_payload(5);
    build_file(VZ_MAGIC_VZF0, VZ_TYPE_BIN, 16'h1000);
    wr_addr_q.delete(); wr_data_q.delete();
    start_dl();
    for (int i = 0; i < 24; i++) put_byte(16'(i), file_q[i], 1);
    for (int i = 0; i < 4; i++) put_byte(16'(24 + i), file_q[24 + i], 1);
    chk("ovf_err_at_full", err, 1'b0);
    chk("ovf_req_pending", bus.mem_req, 1'b1);
    chk("ovf_hold_at_full", cpu_hold, 1'b1);
    put_byte(16'd28, file_q[28], 1);
    chk("ovf_err", err, 1'b1);
    chk("ovf_req_drop", bus.mem_req, 1'b0);
    chk("ovf_hold_drop", cpu_hold, 1'b0);
    end_dl();
    ack_en = 1'b1;
    repeat (10) @(negedge clk_sys);
    chk("ovf_no_writes", wr_addr_q.size(), 0);

    // Truncated header, then a normal download clears the error.
    fill_payload(0);
    build_file(VZ_MAGIC_VZF0, VZ_TYPE_BASIC, 16'h4000);
    start_dl();
    for (int i = 0; i < 10; i++) put_byte(16'(i), file_q[i], 1);
    end_dl();
    chk("trunc_err", err, 1'b1);
    chk("trunc_hold", cpu_hold, 1'b0);
    fill_payload(4);
    run_full(VZ_MAGIC_VZF0, VZ_TYPE_BASIC, 16'h4000, 2, 1'b0);

    // Asynchronous reset with entries stuck in the FIFO.
    ack_en = 1'b0;
    fill_payload(3);
    build_file(VZ_MAGIC_VZF0, VZ_TYPE_BASIC, 16'h2000);
    start_dl();
    for (int i = 0; i < 24; i++) put_byte(16'(i), file_q[i], 1);
    for (int i = 0; i < 3; i++) put_byte(16'(24 + i), file_q[24 + i], 1);
    repeat (2) @(negedge clk_sys);
    chk("arst_req_before", bus.mem_req, 1'b1);
    #2;
    RESET_N = 1'b0;
    bus.dn_download = 1'b0;
    #1;
    chk("arst_mem_req", bus.mem_req, 1'b0);
    chk("arst_cpu_hold", cpu_hold, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_err", err, 1'b0);
    chk("arst_mem_addr", bus.mem_addr, 16'h0);
    chk("arst_mem_data", bus.mem_data, 8'h0);
    chk("arst_load_type", load_type, 8'h0);
    chk("arst_start_addr", start_addr, 16'h0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    RESET_N = 1'b1;
    ack_en  = 1'b1;
    req_base = req_cycles;
    wr_addr_q.delete(); wr_data_q.delete();
    repeat (20) @(negedge clk_sys);
    chk("arst_no_req_after", req_cycles - req_base, 0);
    chk("arst_no_stale_writes", wr_addr_q.size(), 0);
    fill_payload(2);
    run_full(VZ_MAGIC_ALT, VZ_TYPE_BIN, 16'h5123, 1, 1'b1);

    // Randomized downloads.
    for (int r = 0; r < 6; r++) begin
      int n;
      int lat;
      magic = ($urandom_range(0, 1) == 0) ? VZ_MAGIC_VZF0 : VZ_MAGIC_ALT;
      typ   = ($urandom_range(0, 1) == 0) ? VZ_TYPE_BASIC : VZ_TYPE_BIN;
      n     = int'($urandom_range(0, 8));
      lat   = int'($urandom_range(0, 3));
      fill_payload(n);
      run_full(magic, typ, 16'($urandom), lat, (n > 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
